spi_slave_param: RTL

//  Parametrised SPI slave: next generation of the fixed 8-bit slave. Word width and bit order are configurable.
//  TX holding register and RX holding register are double-buffered, with valid/full handshakes and sticky error flags.

---
 rtl/spi_slave_pkg.sv | 40 ++++
 rtl/spi_shift_reg.sv | 44 ++++
 rtl/spi_slave_param.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_pkg.sv
// Shared types and helpers for the parametrised SPI slave: frame state, sticky
// status flags and bit-order aware shift/serial helpers.
package spi_slave_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_state_e;

    typedef struct packed {
        logic rx_overrun;
        logic tx_underrun;
        logic tx_overflow;
    } spi_status_t;

    localparam spi_status_t STATUS_CLEAR = '{rx_overrun: 1'b0, tx_underrun: 1'b0, tx_overflow: 1'b0};

    // Bit counter width; a 2-bit word still needs one counter bit.
    function automatic int cnt_w(input int data_w);
        return (data_w <= 2) ? 1 : $clog2(data_w);
    endfunction

    // Words are carried zero-extended to 32 bits so one helper serves every width.
    function automatic logic [31:0] shift_word(input logic [31:0] w, input logic b,
                                               input bit lsb_first, input int data_w);
        logic [31:0] r;
        if (lsb_first) begin
            r = w >> 1;
            r[5'(data_w - 1)] = b;
        end else begin
            r = {w[30:0], b};
        end
        return r;
    endfunction

    function automatic logic end_bit(input logic [31:0] w, input bit lsb_first, input int data_w);
        return lsb_first ? w[0] : w[5'(data_w - 1)];
    endfunction

endpackage

// File: rtl/spi_shift_reg.sv
// Shift register shared by the TX and RX serial paths; the shift direction
// follows the configured bit order.
module spi_shift_reg
    import spi_slave_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              shift_en,
    input  logic              ser_in,
    output logic [DATA_W-1:0] par_out
);

    logic [DATA_W-1:0] shift_r;
    logic [DATA_W-1:0] shift_next_s;

    // New serial bit enters at the end opposite the one presented on the line
    always_comb begin
        shift_next_s = DATA_W'(shift_word(32'(shift_r), ser_in, LSB_FIRST, DATA_W));
    end

    // Clear beats load, load beats shift
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= {DATA_W{1'b0}};
        end else if (clr) begin
            shift_r <= {DATA_W{1'b0}};
        end else if (load) begin
            shift_r <= load_data;
        end else if (shift_en) begin
            shift_r <= shift_next_s;
        end else begin
            shift_r <= shift_r;
        end
    end

    assign par_out = shift_r;

endmodule

// File: rtl/spi_slave_param.sv
// SPI slave with configurable word width and bit order; double-buffered TX/RX
// holding registers with valid/full handshakes and sticky error flags, all on SCLK.
module spi_slave_param
    import spi_slave_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit LSB_FIRST = 1'b0,
    parameter bit IDLE_MISO = 1'b1
) (
    input  logic              SCLK,
    input  logic              reset,
    input  logic              CS,
    input  logic              MOSI,
    output wire               MISO,
    input  logic [DATA_W-1:0] slaveDataToSend,
    input  logic              wr_en,
    output logic [DATA_W-1:0] slaveDataReceived,
    input  logic              rd_en,
    output logic              tx_full,
    output logic              rx_valid,
    output logic              rx_overrun,
    output logic              tx_underrun,
    output logic              tx_overflow,
    output logic              busy
);

    localparam int               CNT_W    = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    spi_state_e        state_s;
    logic [CNT_W-1:0]  bit_cnt_r, bit_cnt_n_s;
    logic              armed_r, armed_n_s;
    logic [DATA_W-1:0] tx_hold_r, tx_hold_n_s;
    logic              tx_full_r, tx_full_n_s;
    logic [DATA_W-1:0] rx_data_r, rx_data_n_s;
    logic              rx_valid_r, rx_valid_n_s;
    spi_status_t       status_r, status_n_s;

    logic              load_avail_s, consume_s, bypass_s;
    logic [DATA_W-1:0] load_word_s, tx_load_data_s, tx_q_s, rx_q_s, rx_word_s;
    logic              tx_load_s, tx_shift_en_s, tx_ser_s;
    logic              rx_clr_s, rx_shift_en_s, rx_done_s;
    logic              underrun_set_s, overrun_set_s, overflow_set_s;

    // The frame state is simply the chip-select level seen at each edge
    assign state_s      = CS ? IDLE : SHIFT;
    assign load_avail_s = tx_full_r | wr_en;
    assign load_word_s  = tx_full_r ? tx_hold_r : slaveDataToSend;
    assign tx_ser_s     = end_bit(32'(tx_q_s), LSB_FIRST, DATA_W);
    assign rx_word_s    = DATA_W'(shift_word(32'(rx_q_s), MOSI, LSB_FIRST, DATA_W));

    spi_shift_reg #(.DATA_W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_tx_shift (
        .clk      (SCLK),
        .rst      (reset),
        .clr      (1'b0),
        .load     (tx_load_s),
        .load_data(tx_load_data_s),
        .shift_en (tx_shift_en_s),
        .ser_in   (1'b0),
        .par_out  (tx_q_s)
    );

    spi_shift_reg #(.DATA_W(DATA_W), .LSB_FIRST(LSB_FIRST)) u_rx_shift (
        .clk      (SCLK),
        .rst      (reset),
        .clr      (rx_clr_s),
        .load     (1'b0),
        .load_data({DATA_W{1'b0}}),
        .shift_en (rx_shift_en_s),
        .ser_in   (MOSI),
        .par_out  (rx_q_s)
    );

    // Frame sequencing: arming in IDLE, bit counting and word turnover in SHIFT
    always_comb begin
        bit_cnt_n_s    = bit_cnt_r;
        armed_n_s      = armed_r;
        tx_load_s      = 1'b0;
        tx_load_data_s = load_word_s;
        tx_shift_en_s  = 1'b0;
        rx_clr_s       = 1'b0;
        rx_shift_en_s  = 1'b0;
        rx_done_s      = 1'b0;
        underrun_set_s = 1'b0;
        case (state_s)
            IDLE: begin
                bit_cnt_n_s = CNT_ZERO;
                rx_clr_s    = 1'b1;
                // A non-zero count here means the master aborted; the partial TX word is dropped
                if (bit_cnt_r != CNT_ZERO) begin
                    armed_n_s = 1'b0;
                end else if (!armed_r && load_avail_s) begin
                    tx_load_s = 1'b1;
                    armed_n_s = 1'b1;
                end else begin
                    armed_n_s = armed_r;
                end
            end
            SHIFT: begin
                rx_shift_en_s  = 1'b1;
                underrun_set_s = (bit_cnt_r == CNT_ZERO) && !armed_r;
                if (bit_cnt_r == LAST_BIT) begin
                    bit_cnt_n_s = CNT_ZERO;
                    rx_done_s   = 1'b1;
                    tx_load_s   = 1'b1;
                    if (load_avail_s) begin
                        armed_n_s = 1'b1;
                    end else begin
                        tx_load_data_s = {DATA_W{1'b0}};
                        armed_n_s      = 1'b0;
                    end
                end else begin
                    bit_cnt_n_s   = bit_cnt_r + CNT_W'(1'b1);
                    tx_shift_en_s = 1'b1;
                end
            end
            default: begin
                bit_cnt_n_s = CNT_ZERO;
                armed_n_s   = 1'b0;
            end
        endcase
    end

    // TX hold: a write to a full hold survives only if this edge empties it
    always_comb begin
        consume_s      = tx_load_s & tx_full_r;
        bypass_s       = tx_load_s & ~tx_full_r & wr_en;
        tx_hold_n_s    = tx_hold_r;
        tx_full_n_s    = tx_full_r;
        overflow_set_s = 1'b0;
        if (wr_en) begin
            if (!tx_full_r) begin
                if (bypass_s) begin
                    tx_full_n_s = 1'b0;
                end else begin
                    tx_hold_n_s = slaveDataToSend;
                    tx_full_n_s = 1'b1;
                end
            end else if (consume_s) begin
                tx_hold_n_s = slaveDataToSend;
                tx_full_n_s = 1'b1;
            end else begin
                overflow_set_s = 1'b1;
            end
        end else if (consume_s) begin
            tx_full_n_s = 1'b0;
        end else begin
            tx_full_n_s = tx_full_r;
        end
    end

    // RX hold: a completed word always overwrites; a same-edge read avoids overrun
    always_comb begin
        rx_data_n_s   = rx_data_r;
        rx_valid_n_s  = rx_valid_r;
        overrun_set_s = 1'b0;
        if (rx_done_s) begin
            rx_data_n_s   = rx_word_s;
            rx_valid_n_s  = 1'b1;
            overrun_set_s = rx_valid_r & ~rd_en;
        end else if (rd_en) begin
            rx_valid_n_s = 1'b0;
        end else begin
            rx_valid_n_s = rx_valid_r;
        end
    end

    // Sticky flags, cleared only by reset
    always_comb begin
        status_n_s             = status_r;
        status_n_s.rx_overrun  = status_r.rx_overrun  | overrun_set_s;
        status_n_s.tx_underrun = status_r.tx_underrun | underrun_set_s;
        status_n_s.tx_overflow = status_r.tx_overflow | overflow_set_s;
    end

    // State register
    always_ff @(posedge SCLK or posedge reset) begin
        if (reset) begin
            bit_cnt_r  <= CNT_ZERO;
            armed_r    <= 1'b0;
            tx_hold_r  <= {DATA_W{1'b0}};
            tx_full_r  <= 1'b0;
            rx_data_r  <= {DATA_W{1'b0}};
            rx_valid_r <= 1'b0;
            status_r   <= STATUS_CLEAR;
        end else begin
            bit_cnt_r  <= bit_cnt_n_s;
            armed_r    <= armed_n_s;
            tx_hold_r  <= tx_hold_n_s;
            tx_full_r  <= tx_full_n_s;
            rx_data_r  <= rx_data_n_s;
            rx_valid_r <= rx_valid_n_s;
            status_r   <= status_n_s;
        end
    end

    assign MISO              = (reset || (state_s == IDLE)) ? (IDLE_MISO ? 1'bz : 1'b0) : tx_ser_s;
    assign busy              = !CS && (bit_cnt_r != CNT_ZERO);
    assign slaveDataReceived = rx_data_r;
    assign tx_full           = tx_full_r;
    assign rx_valid          = rx_valid_r;
    assign rx_overrun        = status_r.rx_overrun;
    assign tx_underrun       = status_r.tx_underrun;
    assign tx_overflow       = status_r.tx_overflow;

endmodule
